// File: rtl/ap_controller_multi.sv
// Multi-channel ap_ctrl_hs start/finish controller: per-channel start queue,
// in-flight tracking, completion counting and sticky protocol error flags.
module ap_controller_multi #(
    parameter int NUM_CH     = 2,
    parameter int MAX_PEND   = 3,
    parameter int MAX_FLIGHT = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NUM_CH-1:0]       start_trig,
    input  logic [NUM_CH-1:0]       cont_mode,
    input  logic [NUM_CH-1:0]       clr_err,
    output logic [NUM_CH-1:0]       finish,
    output logic [NUM_CH-1:0]       idle,
    output logic [NUM_CH-1:0]       pend_full,
    output logic [NUM_CH-1:0]       ovf_err,
    output logic [NUM_CH-1:0]       proto_err,
    output logic [NUM_CH*CNT_W-1:0] done_count,
    output logic [NUM_CH-1:0]       ap_start,
    input  logic [NUM_CH-1:0]       ap_ready,
    input  logic [NUM_CH-1:0]       ap_done,
    input  logic [NUM_CH-1:0]       ap_idle
);

    localparam int PEND_W = (MAX_PEND < 1) ? 1 : $clog2(MAX_PEND + 1);
    localparam int FL_W   = (MAX_FLIGHT < 1) ? 1 : $clog2(MAX_FLIGHT + 1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PEND_W-1:0] pend_q, pend_d;
        logic [FL_W-1:0]   fl_q, fl_d;
        logic [CNT_W-1:0]  cnt_q;
        logic              ovf_q, proto_q;
        logic              start, accept, trig, done;
        logic              ovf_set, proto_set;

        assign trig   = start_trig[g];
        assign done   = ap_done[g];
        assign start  = trig | (pend_q != '0) | cont_mode[g];
        assign accept = start & ap_ready[g];

        always_comb begin
            pend_d  = pend_q;
            ovf_set = 1'b0;
            if (trig && !accept) begin
                if (pend_q == PEND_W'(MAX_PEND))
                    ovf_set = 1'b1;
                else
                    pend_d = pend_q + 1'b1;
            end else if (!trig && accept && pend_q != '0) begin
                pend_d = pend_q - 1'b1;
            end
        end

        // Accept and done in the same cycle cancel out, even at the bounds.
        always_comb begin
            fl_d      = fl_q;
            proto_set = 1'b0;
            if (accept && !done) begin
                if (fl_q == FL_W'(MAX_FLIGHT))
                    proto_set = 1'b1;
                else
                    fl_d = fl_q + 1'b1;
            end else if (done && !accept) begin
                if (fl_q == '0)
                    proto_set = 1'b1;
                else
                    fl_d = fl_q - 1'b1;
            end
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                pend_q  <= '0;
                fl_q    <= '0;
                ovf_q   <= 1'b0;
                proto_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                pend_q  <= pend_d;
                fl_q    <= fl_d;
                ovf_q   <= ovf_set | (ovf_q & ~clr_err[g]);
                proto_q <= proto_set | (proto_q & ~clr_err[g]);
                cnt_q   <= (clr_err[g] ? '0 : cnt_q) + CNT_W'(done);
            end
        end

        assign ap_start[g]                  = start;
        assign finish[g]                    = done;
        assign idle[g]                      = ap_idle[g] & (pend_q == '0) & (fl_q == '0)
                                              & ~cont_mode[g] & ~trig;
        assign pend_full[g]                 = (pend_q == PEND_W'(MAX_PEND));
        assign ovf_err[g]                   = ovf_q;
        assign proto_err[g]                 = proto_q;
        assign done_count[g*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_ap_controller_multi.sv
// Bench for ap_controller_multi: directed scenarios plus randomized traffic,
// all checked every cycle against a counter-based behavioural model.
module tb_ap_controller_multi;

    localparam int NUM_CH     = 2;
    localparam int MAX_PEND   = 3;
    localparam int MAX_FLIGHT = 2;
    localparam int CNT_W      = 16;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst_n = 1'b0;
    logic [NUM_CH-1:0]       start_trig = '0;
    logic [NUM_CH-1:0]       cont_mode = '0;
    logic [NUM_CH-1:0]       clr_err = '0;
    logic [NUM_CH-1:0]       finish;
    logic [NUM_CH-1:0]       idle;
    logic [NUM_CH-1:0]       pend_full;
    logic [NUM_CH-1:0]       ovf_err;
    logic [NUM_CH-1:0]       proto_err;
    logic [NUM_CH*CNT_W-1:0] done_count;
    logic [NUM_CH-1:0]       ap_start;
    logic [NUM_CH-1:0]       ap_ready = '0;
    logic [NUM_CH-1:0]       ap_done = '0;
    logic [NUM_CH-1:0]       ap_idle = '0;

    int total = 0;
    int bad   = 0;

    int          m_pend [NUM_CH];
    int          m_fl   [NUM_CH];
    bit          m_ovf  [NUM_CH];
    bit          m_proto[NUM_CH];
    int unsigned m_cnt  [NUM_CH];

    ap_controller_multi #(
        .NUM_CH(NUM_CH), .MAX_PEND(MAX_PEND), .MAX_FLIGHT(MAX_FLIGHT), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .start_trig(start_trig), .cont_mode(cont_mode), .clr_err(clr_err),
        .finish(finish), .idle(idle), .pend_full(pend_full),
        .ovf_err(ovf_err), .proto_err(proto_err), .done_count(done_count),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0; m_fl[i] = 0; m_ovf[i] = 0; m_proto[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Compare every output against the model given the inputs now applied.
    task automatic compare();
        logic [NUM_CH-1:0]       e_start, e_idle, e_full, e_ovf, e_proto;
        logic [NUM_CH*CNT_W-1:0] e_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            e_start[i] = start_trig[i] || m_pend[i] > 0 || cont_mode[i];
            e_idle[i]  = ap_idle[i] && m_pend[i] == 0 && m_fl[i] == 0 && !cont_mode[i] && !start_trig[i];
            e_full[i]  = (m_pend[i] == MAX_PEND);
            e_ovf[i]   = m_ovf[i];
            e_proto[i] = m_proto[i];
            e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        end
        check("ap_start",   64'(ap_start),   64'(e_start));
        check("finish",     64'(finish),     64'(ap_done));
        check("idle",       64'(idle),       64'(e_idle));
        check("pend_full",  64'(pend_full),  64'(e_full));
        check("ovf_err",    64'(ovf_err),    64'(e_ovf));
        check("proto_err",  64'(proto_err),  64'(e_proto));
        check("done_count", 64'(done_count), 64'(e_cnt));
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            bit st, acc, ovf_s, pro_s;
            st    = start_trig[i] || m_pend[i] > 0 || cont_mode[i];
            acc   = st && ap_ready[i];
            ovf_s = 0;
            pro_s = 0;
            if (start_trig[i] && !acc) begin
                if (m_pend[i] == MAX_PEND) ovf_s = 1; else m_pend[i]++;
            end else if (!start_trig[i] && acc && m_pend[i] > 0) begin
                m_pend[i]--;
            end
            if (acc && !ap_done[i]) begin
                if (m_fl[i] == MAX_FLIGHT) pro_s = 1; else m_fl[i]++;
            end else if (ap_done[i] && !acc) begin
                if (m_fl[i] == 0) pro_s = 1; else m_fl[i]--;
            end
            m_ovf[i]   = ovf_s || (m_ovf[i] && !clr_err[i]);
            m_proto[i] = pro_s || (m_proto[i] && !clr_err[i]);
            m_cnt[i]   = ((clr_err[i] ? 0 : m_cnt[i]) + (ap_done[i] ? 1 : 0)) % (1 << CNT_W);
        end
    endtask

    // One cycle: drive on the falling edge, compare, then let the rising edge land.
    task automatic tick(input logic [NUM_CH-1:0] trig, input logic [NUM_CH-1:0] cont,
                        input logic [NUM_CH-1:0] clr, input logic [NUM_CH-1:0] rdy,
                        input logic [NUM_CH-1:0] dn, input logic [NUM_CH-1:0] aid);
        @(negedge ap_clk);
        start_trig = trig; cont_mode = cont; clr_err = clr;
        ap_ready = rdy; ap_done = dn; ap_idle = aid;
        #1;
        compare();
        model_step();
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_ap_start",   64'(ap_start),   64'h0);
        check("rst_pend_full",  64'(pend_full),  64'h0);
        check("rst_done_count", 64'(done_count), 64'h0);
        check("rst_errs",       64'({ovf_err, proto_err}), 64'h0);
        #11 ap_rst_n = 1'b1;

        // Single trigger accepted immediately, done five cycles later.
        tick(2'b01, 0, 0, 2'b01, 0, 0);
        check("single_start", 64'(ap_start[0]), 64'h1);
        repeat (4) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 2'b01, 2'b11);
        check("single_finish", 64'(finish[0]), 64'h1);
        tick(0, 0, 0, 0, 0, 2'b11);
        check("single_idle", 64'(idle[0]), 64'h1);
        check("single_cnt",  64'(done_count[CNT_W-1:0]), 64'd1);

        // Queue overflow, then drain with ready and done together.
        repeat (4) tick(2'b01, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("ovf_full", 64'(pend_full[0]), 64'h1);
        check("ovf_err",  64'(ovf_err[0]),   64'h1);
        repeat (3) tick(0, 0, 0, 2'b01, 2'b01, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("drain_start", 64'(ap_start[0]), 64'h0);
        check("drain_cnt",   64'(done_count[CNT_W-1:0]), 64'd4);

        // Trigger coincident with accept leaves the queue depth unchanged.
        repeat (2) tick(2'b01, 0, 0, 0, 0, 0);
        tick(2'b01, 0, 0, 2'b01, 2'b01, 0);
        tick(2'b01, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("pass_full", 64'(pend_full[0]), 64'h1);
        repeat (3) tick(0, 0, 0, 2'b01, 2'b01, 0);
        check("ch1_quiet", 64'({ap_start[1], done_count[2*CNT_W-1:CNT_W]}), 64'h0);

        // Continuous mode.
        tick(0, 2'b01, 0, 0, 0, 0);
        check("cont_start", 64'(ap_start[0]), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick(0, 2'b01, 0, 2'b01, 0, 0);
            tick(0, 2'b01, 0, 0, 2'b01, 0);
            tick(0, 2'b01, 0, 0, 0, 0);
        end
        tick(0, 0, 0, 0, 0, 2'b11);
        check("cont_off_start", 64'(ap_start[0]), 64'h0);
        check("cont_off_idle",  64'(idle[0]),     64'h1);

        // Protocol error and clear interactions.
        tick(0, 0, 2'b01, 0, 0, 0);
        tick(0, 0, 0, 0, 2'b01, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("proto_set", 64'(proto_err[0]), 64'h1);
        tick(0, 0, 2'b01, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("clr_proto", 64'(proto_err[0]), 64'h0);
        check("clr_cnt",   64'(done_count[CNT_W-1:0]), 64'd0);
        tick(0, 0, 2'b01, 0, 2'b01, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("clr_done_cnt", 64'(done_count[CNT_W-1:0]), 64'd1);

        // Counter wrap.
        tick(0, 0, 2'b01, 0, 0, 0);
        repeat (65535) tick(0, 0, 0, 0, 2'b01, 0);
        tick(0, 0, 0, 0, 2'b01, 0);
        check("cnt_max", 64'(done_count[CNT_W-1:0]), 64'hFFFF);
        tick(0, 0, 0, 0, 0, 0);
        check("cnt_wrap", 64'(done_count[CNT_W-1:0]), 64'h0);

        // Asynchronous reset with two requests queued.
        repeat (2) tick(2'b01, 0, 0, 0, 0, 0);
        @(negedge ap_clk);
        start_trig = '0; cont_mode = '0; clr_err = '0; ap_ready = '0; ap_done = '0; ap_idle = '0;
        #1;
        check("pre_rst_start", 64'(ap_start[0]), 64'h1);
        ap_rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_start", 64'(ap_start),  64'h0);
        check("arst_full",  64'(pend_full), 64'h0);
        compare();
        #1 ap_rst_n = 1'b1;

        // Randomized traffic on both channels.
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] t, c, cl, r, d, a;
            for (int i = 0; i < NUM_CH; i++) begin
                t[i]  = ($urandom_range(0, 2) == 0);
                c[i]  = ($urandom_range(0, 9) == 0);
                cl[i] = ($urandom_range(0, 31) == 0);
                r[i]  = ($urandom_range(0, 2) == 0);
                d[i]  = ($urandom_range(0, 3) == 0);
                a[i]  = ($urandom_range(0, 1) == 0);
            end
            tick(t, c, cl, r, d, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
